rtc_bus_sequencer: RTL and testbench

- Generates multiplexed address/data bus cycles (CS, AD, RD, WR, 8-bit bidirectional data) to the external RTC chip on behalf of the PicoBlaze port-decode logic.
- Sits directly downstream of the micro's RTC port writes and upstream of the RTC pads.
- Converts single-cycle start requests into timed address-phase plus data-phase transactions.
- Returns read data with a one-cycle valid pulse.

---
 rtl/rtc_bus_sequencer_if.sv | 37 +++
 rtl/rtc_bus_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_sequencer_if
//  Brief    : Host-side handshake plus multiplexed RTC pad bus for the
//             RTC bus sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface rtc_bus_sequencer_if;
  logic       start_write;
  logic       start_read;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;
  logic       done;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;
  logic       CS;
  logic       AD;
  logic       RD;
  logic       WR;

  // Sequencer view
  modport slave (
    input  start_write, start_read, addr, wdata, bus_in,
    output rdata, rdata_valid, busy, done, bus_out, bus_oe, CS, AD, RD, WR
  );

  // Requester / pad view
  modport master (
    output start_write, start_read, addr, wdata, bus_in,
    input  rdata, rdata_valid, busy, done, bus_out, bus_oe, CS, AD, RD, WR
  );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_sequencer
//  Brief    : Turns single-cycle start pulses into timed address + data bus
//             cycles on the multiplexed RTC bus. Optional macro
//             RTC_IRQ_LATCH_EN adds a synchronized, sticky irq_pending flag.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 10,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 5
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_sequencer_if.slave bus
`ifdef RTC_IRQ_LATCH_EN
  ,
  input  logic               irq,
  input  logic               irq_clear,
  output logic               irq_pending
`endif
);

  localparam int C_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int C_MAX_HG = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int C_MAX    = (C_MAX_SP > C_MAX_HG) ? C_MAX_SP : C_MAX_HG;
  localparam int CW       = (C_MAX < 2) ? 1 : $clog2(C_MAX + 1);

  localparam logic [CW-1:0] C_LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] C_LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] C_LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] C_LD_GAP   = CW'(T_GAP - 1);
  localparam logic [CW-1:0] C_CNT_ZERO = '0;
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_A_SET = 4'd1,
    S_A_STB = 4'd2,
    S_A_HLD = 4'd3,
    S_GAP   = 4'd4,
    S_D_SET = 4'd5,
    S_D_STB = 4'd6,
    S_D_HLD = 4'd7,
    S_FIN   = 4'd8
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_cnt_zero;
  logic            w_accept;

  logic            r_op_wr;
  logic            w_op_wr_nxt;
  logic [7:0]      r_addr;
  logic [7:0]      w_addr_nxt;
  logic [7:0]      r_wdata;
  logic [7:0]      w_wdata_nxt;

  logic            r_cs,  w_cs_nxt;
  logic            r_ad,  w_ad_nxt;
  logic            r_rd,  w_rd_nxt;
  logic            r_wr,  w_wr_nxt;
  logic            r_oe,  w_oe_nxt;
  logic [7:0]      r_out, w_out_nxt;
  logic            r_done, w_done_nxt;
  logic            r_rvalid, w_rvalid_nxt;
  logic            r_busy, w_busy_nxt;
  logic [7:0]      r_rdata;
  logic            w_rd_sample;

  // --------------------------------------------------------------------------
  // State, counter, latched request and registered pad/handshake outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op_wr  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cs     <= 1'b1;
      r_ad     <= 1'b1;
      r_rd     <= 1'b1;
      r_wr     <= 1'b1;
      r_oe     <= 1'b0;
      r_out    <= '0;
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op_wr  <= w_op_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_cs     <= w_cs_nxt;
      r_ad     <= w_ad_nxt;
      r_rd     <= w_rd_nxt;
      r_wr     <= w_wr_nxt;
      r_oe     <= w_oe_nxt;
      r_out    <= w_out_nxt;
      r_done   <= w_done_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and counter
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_cnt_zero  = (r_cnt == C_CNT_ZERO);

    case (r_state)
      S_IDLE: begin
        if (bus.start_write || bus.start_read) begin
          w_accept    = 1'b1;
          w_state_nxt = S_A_SET;
          w_cnt_nxt   = C_LD_SETUP;
        end
      end
      S_A_SET: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_A_STB;
          w_cnt_nxt   = C_LD_PULSE;
        end else begin
          w_cnt_nxt   = r_cnt - C_CNT_ONE;
        end
      end
      S_A_STB: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_A_HLD;
          w_cnt_nxt   = C_LD_HOLD;
        end else begin
          w_cnt_nxt   = r_cnt - C_CNT_ONE;
        end
      end
      S_A_HLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = C_LD_GAP;
        end else begin
          w_cnt_nxt   = r_cnt - C_CNT_ONE;
        end
      end
      S_GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_D_SET;
          w_cnt_nxt   = C_LD_SETUP;
        end else begin
          w_cnt_nxt   = r_cnt - C_CNT_ONE;
        end
      end
      S_D_SET: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_D_STB;
          w_cnt_nxt   = C_LD_PULSE;
        end else begin
          w_cnt_nxt   = r_cnt - C_CNT_ONE;
        end
      end
      S_D_STB: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_D_HLD;
          w_cnt_nxt   = C_LD_HOLD;
        end else begin
          w_cnt_nxt   = r_cnt - C_CNT_ONE;
        end
      end
      S_D_HLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_FIN;
          w_cnt_nxt   = C_CNT_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt - C_CNT_ONE;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = C_CNT_ZERO;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = C_CNT_ZERO;
      end
    endcase
  end

  // Write wins a simultaneous request; the read is simply dropped.
  always_comb begin
    w_op_wr_nxt = r_op_wr;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    if (w_accept) begin
      w_op_wr_nxt = bus.start_write;
      w_addr_nxt  = bus.addr;
      w_wdata_nxt = bus.wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from the next state so the pads see clean registered levels
  // --------------------------------------------------------------------------
  always_comb begin
    w_cs_nxt     = 1'b1;
    w_ad_nxt     = 1'b1;
    w_rd_nxt     = 1'b1;
    w_wr_nxt     = 1'b1;
    w_oe_nxt     = 1'b0;
    w_out_nxt    = '0;
    w_done_nxt   = 1'b0;
    w_rvalid_nxt = 1'b0;
    w_busy_nxt   = (w_state_nxt != S_IDLE);

    case (w_state_nxt)
      S_A_SET, S_A_HLD: begin
        w_cs_nxt  = 1'b0;
        w_ad_nxt  = 1'b0;
        w_oe_nxt  = 1'b1;
        w_out_nxt = w_addr_nxt;
      end
      S_A_STB: begin
        w_cs_nxt  = 1'b0;
        w_ad_nxt  = 1'b0;
        w_oe_nxt  = 1'b1;
        w_out_nxt = w_addr_nxt;
        w_wr_nxt  = 1'b0;
      end
      S_D_SET, S_D_HLD: begin
        w_cs_nxt = 1'b0;
        if (w_op_wr_nxt) begin
          w_oe_nxt  = 1'b1;
          w_out_nxt = w_wdata_nxt;
        end
      end
      S_D_STB: begin
        w_cs_nxt = 1'b0;
        if (w_op_wr_nxt) begin
          w_oe_nxt  = 1'b1;
          w_out_nxt = w_wdata_nxt;
          w_wr_nxt  = 1'b0;
        end else begin
          w_rd_nxt  = 1'b0;
        end
      end
      S_FIN: begin
        w_done_nxt   = 1'b1;
        w_rvalid_nxt = ~w_op_wr_nxt;
      end
      default: begin
        w_cs_nxt = 1'b1;
      end
    endcase
  end

  // Sample the pad on the final strobe cycle, while RD is still low.
  assign w_rd_sample = (r_state == S_D_STB) && w_cnt_zero && !r_op_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_rd_sample) begin
      r_rdata <= bus.bus_in;
    end
  end

  assign bus.CS          = r_cs;
  assign bus.AD          = r_ad;
  assign bus.RD          = r_rd;
  assign bus.WR          = r_wr;
  assign bus.bus_oe      = r_oe;
  assign bus.bus_out     = r_out;
  assign bus.done        = r_done;
  assign bus.rdata_valid = r_rvalid;
  assign bus.busy        = r_busy;
  assign bus.rdata       = r_rdata;

`ifdef RTC_IRQ_LATCH_EN
  logic r_irq_s1;
  logic r_irq_s2;
  logic r_irq_s3;
  logic r_irq_pending;
  logic w_irq_fall;

  assign w_irq_fall = r_irq_s3 & ~r_irq_s2;

  // irq idles high, so the synchronizer resets to the inactive level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_s1      <= 1'b1;
      r_irq_s2      <= 1'b1;
      r_irq_s3      <= 1'b1;
      r_irq_pending <= 1'b0;
    end else begin
      r_irq_s1 <= irq;
      r_irq_s2 <= r_irq_s1;
      r_irq_s3 <= r_irq_s2;
      if (w_irq_fall) begin
        r_irq_pending <= 1'b1;
      end else if (irq_clear) begin
        r_irq_pending <= 1'b0;
      end
    end
  end

  assign irq_pending = r_irq_pending;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_bus_sequencer
//  Brief    : Self-checking bench for rtc_bus_sequencer: table of bus
//             transactions with a scoreboard, plus hand-written corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_sequencer;

  localparam int C_TXN_LEN = 34;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] pad_val = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_bus_sequencer_if bif ();

  assign bif.bus_in = bif.RD ? 8'hEE : pad_val;

`ifdef RTC_IRQ_LATCH_EN
  logic irq = 1'b1;
  logic irq_clear = 1'b0;
  logic irq_pending;
`endif

  rtc_bus_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
`ifdef RTC_IRQ_LATCH_EN
    ,
    .irq        (irq),
    .irq_clear  (irq_clear),
    .irq_pending(irq_pending)
`endif
  );

  // op: 0 = write, 1 = read, 2 = write and read in the same cycle
  typedef struct {
    int         op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] pad;
  } vec_t;

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drives one start pulse; optionally records the transaction it should cause.
  task automatic start_txn(input int op, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] pad, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    bif.start_write = (op != 1);
    bif.start_read  = (op != 0);
    bif.addr        = a;
    bif.wdata       = d;
    if (push) begin
      pad_val    = pad;
      e.rd       = (op == 1);
      e.addr     = a;
      e.data     = (op == 1) ? pad : d;
      e.done_cyc = cyc + C_TXN_LEN;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bif.start_write = 1'b0;
    bif.start_read  = 1'b0;
    if (push) chk("busy_after_accept", 32'(bif.busy), 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  // --------------------------------------------------------------------------
  // Bus monitor / scoreboard checker
  // --------------------------------------------------------------------------
  int         a_cnt, d_wr, d_rd, d_oe;
  logic [7:0] a_addr, d_data;
  exp_t       em;

  initial begin
    a_cnt = 0; d_wr = 0; d_rd = 0; d_oe = 0; a_addr = 0; d_data = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        a_cnt = 0; d_wr = 0; d_rd = 0; d_oe = 0;
      end else begin
        chk("rd_wr_exclusive", 32'(!bif.RD && !bif.WR), 0);
        chk("oe_while_rd_low", 32'(bif.bus_oe && !bif.RD), 0);
        if (!bif.CS && !bif.AD && !bif.WR) begin
          a_cnt++;
          a_addr = bif.bus_out;
        end
        if (!bif.CS && bif.AD) begin
          if (!bif.WR) begin
            d_wr++;
            d_data = bif.bus_out;
          end
          if (!bif.RD) d_rd++;
          if (bif.bus_oe) d_oe++;
        end
        if (bif.done) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL done_expected: got unexpected done at cycle %0d, expected none", cyc);
          end else begin
            em = sb.pop_front();
            chk("done_latency", cyc, em.done_cyc);
            chk("addr_phase_addr", a_addr, em.addr);
            chk("addr_strobe_width", a_cnt, 10);
            chk("rdata_valid_on_done", 32'(bif.rdata_valid), 32'(em.rd));
            if (em.rd) begin
              chk("read_strobe_width", d_rd, 10);
              chk("read_no_wr_strobe", d_wr, 0);
              chk("read_data_oe_cycles", d_oe, 0);
              chk("read_rdata", bif.rdata, em.data);
            end else begin
              chk("write_strobe_width", d_wr, 10);
              chk("write_no_rd_strobe", d_rd, 0);
              chk("write_data_oe_cycles", d_oe, 14);
              chk("write_data", d_data, em.data);
            end
          end
          a_cnt = 0; d_wr = 0; d_rd = 0; d_oe = 0;
        end else begin
          chk("rdata_valid_only_with_done", 32'(bif.rdata_valid), 0);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  vec_t       vecs[6];
  logic [7:0] last_rd;

  initial begin
    bif.start_write = 1'b0;
    bif.start_read  = 1'b0;
    bif.addr        = 8'h00;
    bif.wdata       = 8'h00;

    vecs[0] = '{op: 0, addr: 8'h21, wdata: 8'h59, pad: 8'h00};
    vecs[1] = '{op: 1, addr: 8'h22, wdata: 8'h00, pad: 8'h37};
    vecs[2] = '{op: 2, addr: 8'h30, wdata: 8'h6C, pad: 8'h99};
    vecs[3] = '{op: 1, addr: 8'h0F, wdata: 8'h00, pad: 8'hC3};
    vecs[4] = '{op: 0, addr: 8'hFF, wdata: 8'h00, pad: 8'h00};
    vecs[5] = '{op: 1, addr: 8'h00, wdata: 8'h00, pad: 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_CS", 32'(bif.CS), 1);
    chk("reset_AD", 32'(bif.AD), 1);
    chk("reset_RD", 32'(bif.RD), 1);
    chk("reset_WR", 32'(bif.WR), 1);
    chk("reset_bus_oe", 32'(bif.bus_oe), 0);
    chk("reset_bus_out", bif.bus_out, 0);
    chk("reset_rdata", bif.rdata, 0);
    chk("reset_rdata_valid", 32'(bif.rdata_valid), 0);
    chk("reset_busy", 32'(bif.busy), 0);
    chk("reset_done", 32'(bif.done), 0);
    reset = 1'b0;

    // Table-driven transactions, issued back to back
    last_rd = 8'h00;
    for (int i = 0; i < 6; i++) begin
      start_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].pad, 1'b1);
      wait_drain();
      if (vecs[i].op == 1) last_rd = vecs[i].pad;
      chk("rdata_hold", bif.rdata, last_rd);
    end

    // Start arriving mid-transaction is ignored
    start_txn(0, 8'h10, 8'hA5, 8'h00, 1'b1);
    repeat (12) @(posedge clk);
    start_txn(1, 8'h99, 8'h00, 8'h5A, 1'b0);
    wait_drain();
    repeat (40) @(posedge clk);
    #1;
    chk("ignored_start_idle_busy", 32'(bif.busy), 0);
    chk("ignored_start_rdata_kept", bif.rdata, last_rd);

    // Reset during the address strobe
    start_txn(0, 8'h44, 8'h55, 8'h00, 1'b1);
    for (int i = 0; i < 20 && !(!bif.WR && !bif.AD); i++) @(negedge clk);
    chk("reached_addr_strobe", 32'(!bif.WR && !bif.AD), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_CS", 32'(bif.CS), 1);
    chk("midrst_AD", 32'(bif.AD), 1);
    chk("midrst_RD", 32'(bif.RD), 1);
    chk("midrst_WR", 32'(bif.WR), 1);
    chk("midrst_bus_oe", 32'(bif.bus_oe), 0);
    chk("midrst_busy", 32'(bif.busy), 0);
    chk("midrst_done", 32'(bif.done), 0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    start_txn(1, 8'h2A, 8'h00, 8'h81, 1'b1);
    wait_drain();

`ifdef RTC_IRQ_LATCH_EN
    @(posedge clk);
    #1;
    chk("irq_pending_idle", 32'(irq_pending), 0);
    irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    irq = 1'b1;
    chk("irq_pending_set", 32'(irq_pending), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("irq_pending_sticky", 32'(irq_pending), 1);
    irq_clear = 1'b1;
    @(posedge clk);
    #1;
    irq_clear = 1'b0;
    chk("irq_pending_cleared", 32'(irq_pending), 0);
    repeat (2) @(posedge clk);
    #1;
    irq = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    irq_clear = 1'b1;
    @(posedge clk);
    #1;
    irq_clear = 1'b0;
    chk("irq_set_wins_over_clear", 32'(irq_pending), 1);
    irq = 1'b1;
`endif

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
